// File: rtl/mux_scan_sequencer.sv
// Steps a 16:1 (2**SEL_WIDTH:1) mux through every channel, samples its output after a settle
// window and reports the packed word. Optional MUX_SCAN_CONT_EN adds a `cont` input for gapless rescans.
module mux_scan_sequencer #(
    parameter int SEL_WIDTH     = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
`ifdef MUX_SCAN_CONT_EN
    input  logic                      cont,
`endif
    input  logic                      mux_out,
    output logic [SEL_WIDTH-1:0]      sel,
    output logic                      busy,
    output logic                      data_valid,
    output logic [2**SEL_WIDTH-1:0]   data_out
);
    localparam int NUM_CH = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CH - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_t;

    // With no settle window every channel is sampled on consecutive edges.
    localparam state_t RELOAD_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_CH-1:0]      shadow_q, shadow_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [NUM_CH-1:0]      dout_q, dout_d;
    logic                   cont_now;

`ifdef MUX_SCAN_CONT_EN
    assign cont_now = cont;
`else
    assign cont_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        dout_d   = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_LD;
                    state_d = RELOAD_ST;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    shadow_d[sel_q] = mux_out;
                    if (sel_q != LAST_CH) begin
                        sel_d   = sel_q + 1'b1;
                        cnt_d   = SETTLE_LD;
                        state_d = RELOAD_ST;
                    end else begin
                        // The published word must include the bit captured on this very edge.
                        dout_d  = shadow_d;
                        valid_d = 1'b1;
                        sel_d   = '0;
                        if (cont_now) begin
                            cnt_d   = SETTLE_LD;
                            state_d = RELOAD_ST;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign data_out   = dout_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Three sequencers (settle 1, 0, 3) each scanning a bench-side 16:1 mux; expectations come from
// the scan timing rules: sel = t/(S+1), result at t = 16*(S+1), abort and reset leave fixed values.
module tb_mux_scan_sequencer;
    logic        clk;
    logic        rst_n;
    logic [2:0]  start_r;
    logic [2:0]  abort_r;
`ifdef MUX_SCAN_CONT_EN
    logic [2:0]  cont_r;
`endif
    logic [15:0] a_in     [3];
    logic [3:0]  sel_w    [3];
    logic        busy_w   [3];
    logic        dv_w     [3];
    logic [15:0] dout_w   [3];
    logic [15:0] prev_word[3];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
            logic mo;
            assign mo = a_in[gi][sel_w[gi]];
            mux_scan_sequencer #(.SEL_WIDTH(4), .SETTLE_CYCLES(ST)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start_r[gi]),
                .abort      (abort_r[gi]),
`ifdef MUX_SCAN_CONT_EN
                .cont       (cont_r[gi]),
`endif
                .mux_out    (mo),
                .sel        (sel_w[gi]),
                .busy       (busy_w[gi]),
                .data_valid (dv_w[gi]),
                .data_out   (dout_w[gi])
            );
        end
    endgenerate

    function automatic int settle_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // abort_at > 0: abort raised for edge t=abort_at; abort_at < 0: abort raised together with start.
    // pre: start was already raised by the previous scan's completion cycle.
    task automatic run_scan(input int idx, input logic [15:0] word, input int abort_at,
                            input bit pre, input bit b2b);
        int per;
        int total;
        per   = settle_of(idx) + 1;
        total = 16 * per;
        a_in[idx] = word;
        if (!pre) start_r[idx] = 1'b1;
        if (abort_at < 0) abort_r[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[idx] = 1'b0;
        abort_r[idx] = 1'b0;
        check_eq("start_busy", 32'(busy_w[idx]), 32'd1);
        check_eq("start_sel", 32'(sel_w[idx]), 32'd0);
        check_eq("start_dv", 32'(dv_w[idx]), 32'd0);
        for (int t = 1; t <= total; t++) begin
            start_r[idx] = (t == 3);
            abort_r[idx] = (abort_at > 0) && (t == abort_at);
            @(posedge clk);
            @(negedge clk);
            start_r[idx] = 1'b0;
            abort_r[idx] = 1'b0;
            if (abort_at > 0 && t == abort_at) begin
                check_eq("abort_busy", 32'(busy_w[idx]), 32'd0);
                check_eq("abort_sel", 32'(sel_w[idx]), 32'd0);
                check_eq("abort_dv", 32'(dv_w[idx]), 32'd0);
                check_eq("abort_dout", 32'(dout_w[idx]), 32'(prev_word[idx]));
                @(posedge clk);
                @(negedge clk);
                check_eq("abort_idle_dv", 32'(dv_w[idx]), 32'd0);
                $display("scan inst=%0d settle=%0d word=%h aborted_at=%0d", idx, per - 1, word, t);
                return;
            end
            if (t < total) begin
                check_eq("scan_sel", 32'(sel_w[idx]), 32'(t / per));
                check_eq("scan_busy", 32'(busy_w[idx]), 32'd1);
                check_eq("scan_dv", 32'(dv_w[idx]), 32'd0);
                check_eq("scan_dout_hold", 32'(dout_w[idx]), 32'(prev_word[idx]));
            end else begin
                check_eq("done_dv", 32'(dv_w[idx]), 32'd1);
                check_eq("done_busy", 32'(busy_w[idx]), 32'd0);
                check_eq("done_sel", 32'(sel_w[idx]), 32'd0);
                check_eq("done_dout", 32'(dout_w[idx]), 32'(word));
                prev_word[idx] = word;
                if (b2b) start_r[idx] = 1'b1;
            end
        end
        if (!b2b) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("idle_dv", 32'(dv_w[idx]), 32'd0);
            check_eq("idle_busy", 32'(busy_w[idx]), 32'd0);
            check_eq("idle_dout", 32'(dout_w[idx]), 32'(prev_word[idx]));
        end
        $display("scan inst=%0d settle=%0d word=%h cycles=%0d b2b=%0b", idx, per - 1, word, total, b2b);
    endtask

    initial begin
        bit          pend;
        int          pidx;
        int          idx;
        int          ab;
        bit          b2b;
        logic [15:0] w;
        rst_n   = 1'b0;
        start_r = '0;
        abort_r = '0;
`ifdef MUX_SCAN_CONT_EN
        cont_r  = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            a_in[i]      = '0;
            prev_word[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_sel", 32'(sel_w[i]), 32'd0);
            check_eq("rst_busy", 32'(busy_w[i]), 32'd0);
            check_eq("rst_dv", 32'(dv_w[i]), 32'd0);
            check_eq("rst_dout", 32'(dout_w[i]), 32'd0);
        end

        run_scan(0, 16'hA5C3, 0, 1'b0, 1'b0);
        run_scan(1, 16'h8001, 0, 1'b0, 1'b0);
        run_scan(2, 16'h8001, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-scan while sel = 7.
        a_in[0]    = 16'h5A5A;
        start_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("pre_rst_sel", 32'(sel_w[0]), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_sel", 32'(sel_w[0]), 32'd0);
        check_eq("async_rst_busy", 32'(busy_w[0]), 32'd0);
        check_eq("async_rst_dv", 32'(dv_w[0]), 32'd0);
        check_eq("async_rst_dout", 32'(dout_w[0]), 32'd0);
        check_eq("async_rst_dout2", 32'(dout_w[2]), 32'd0);
        for (int i = 0; i < 3; i++) prev_word[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset inst=0 asserted at sel=7");

        run_scan(0, 16'h1234, 0, 1'b0, 1'b0);
        run_scan(0, 16'hBEEF, 19, 1'b0, 1'b0);

        // Abort while idle must leave everything untouched.
        abort_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_r[0] = 1'b0;
        check_eq("idle_abort_busy", 32'(busy_w[0]), 32'd0);
        check_eq("idle_abort_dout", 32'(dout_w[0]), 32'(prev_word[0]));
        $display("idle abort inst=0");

        run_scan(1, 16'h00FF, -1, 1'b0, 1'b0);
        run_scan(0, 16'hFFFF, 0, 1'b0, 1'b1);
        run_scan(0, 16'h0F0F, 0, 1'b1, 1'b0);

        pend = 1'b0;
        pidx = 0;
        for (int n = 0; n < 24; n++) begin
            idx = pend ? pidx : int'($urandom_range(0, 2));
            ab  = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(4, 16 * (settle_of(idx) + 1) - 1)) : 0;
            b2b = (ab == 0) && ($urandom_range(0, 1) == 1);
            w   = 16'($urandom);
            run_scan(idx, w, ab, pend, b2b);
            pend = b2b;
            pidx = idx;
        end
        if (pend) run_scan(pidx, 16'($urandom), 0, 1'b1, 1'b0);

`ifdef MUX_SCAN_CONT_EN
        begin
            logic [15:0] words[4];
            for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
            cont_r[0]  = 1'b1;
            a_in[0]    = words[0];
            start_r[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_r[0] = 1'b0;
            check_eq("cont_start_busy", 32'(busy_w[0]), 32'd1);
            for (int t = 1; t <= 128; t++) begin
                @(posedge clk);
                @(negedge clk);
                if (t % 32 == 0) begin
                    check_eq("cont_dv", 32'(dv_w[0]), 32'd1);
                    check_eq("cont_dout", 32'(dout_w[0]), 32'(words[t / 32 - 1]));
                    check_eq("cont_sel", 32'(sel_w[0]), 32'd0);
                    check_eq("cont_busy", 32'(busy_w[0]), (t == 128) ? 32'd0 : 32'd1);
                    $display("cont scan inst=0 n=%0d word=%h", t / 32, words[t / 32 - 1]);
                    if (t < 128) a_in[0] = words[t / 32];
                    if (t == 96) cont_r[0] = 1'b0;
                end else begin
                    check_eq("cont_run_sel", 32'(sel_w[0]), 32'((t % 32) / 2));
                    check_eq("cont_run_busy", 32'(busy_w[0]), 32'd1);
                    check_eq("cont_run_dv", 32'(dv_w[0]), 32'd0);
                end
            end
            prev_word[0] = words[3];
            @(posedge clk);
            @(negedge clk);
            check_eq("cont_end_busy", 32'(busy_w[0]), 32'd0);
            check_eq("cont_end_dv", 32'(dv_w[0]), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
